bin2bcd_seq: RTL and testbench

Sequential shift-add-3 (double-dabble) binary-to-BCD converter with valid/ready handshakes on both sides. It sits directly upstream of the seven-segment decoders: each 4-bit slice of `bcd_o` drives one decoder's `bin_i`. Counter or dimmer values can therefore be shown in decimal instead of hex. Its result register stays stable between conversions, so decoders can read it continuously.

---
 rtl/bin2bcd_pkg.sv | 25 ++
 rtl/bin2bcd_seq_digit_adj.sv | 21 ++
 rtl/bin2bcd_seq.sv | 173 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bin2bcd_state_t : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W     : bits per BCD digit
//   bcd_max(d)      : largest value representable in d decimal digits (10^d - 1)
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bin2bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic int unsigned bcd_max(input int digits);
        int unsigned acc;
        acc = 1;
        for (int i = 0; i < digits; i++) begin
            acc = acc * 10;
        end
        return acc - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
//   digit    : current 4-bit BCD digit
//   adjusted : digit after the conditional +3 (never exceeds 4 bits for 0..9)
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential shift-add-3 binary-to-BCD converter with valid/ready on both
// sides. One input bit is processed per cycle; the result registers hold
// their value between conversions so display decoders can read them freely.
//
// Optional feature macro: BIN2BCD_BLANK_EN (leading-zero blanking on blank_o).
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   bin_i    : binary input, sampled on accept
//   valid_i  : upstream offers bin_i (only honoured in IDLE)
//   ready_o  : converter idle and able to accept
//   bcd_o    : result, digit k at [4k+3:4k], k=0 is units
//   blank_o  : per-digit leading-zero blank request (0 when feature disabled)
//   ovf_o    : last accepted input exceeded 10^DIGITS-1 (result saturated)
//   valid_o  : result available (held until ready_i)
//   ready_i  : downstream consumes result
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [WIDTH-1:0]              bin_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic [DIGITS-1:0]             blank_o,
    output logic                          ovf_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    localparam int          BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam int unsigned MAX_VAL  = bcd_max(DIGITS);
    localparam int          MAX_BITS = $clog2(MAX_VAL + 1);
    // Wide enough to hold both the input and the saturation limit.
    localparam int          CMP_W    = (WIDTH > MAX_BITS) ? WIDTH : MAX_BITS;
    localparam int          CNT_W    = $clog2(WIDTH);
    localparam logic [CMP_W-1:0] MAX_CMP  = CMP_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    bin2bcd_state_t state_reg, state_next;

    logic [WIDTH-1:0] op_reg;
    logic [BCD_W-1:0] scratch_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_pend_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic             ovf_reg;

    // Saturation: anything beyond the displayable range shows as all nines.
    logic             sat;
    logic [WIDTH-1:0] operand;

    assign sat     = (CMP_W'(bin_i) > MAX_CMP);
    assign operand = sat ? MAX_CMP[WIDTH-1:0] : bin_i;

    // Per-digit add-3, then shift {scratch, operand} left by one bit.
    logic [BCD_W-1:0]       scratch_adj;
    logic [BCD_W+WIDTH-1:0] shift_full;
    logic [BCD_W-1:0]       scratch_shift;
    logic [WIDTH-1:0]       op_shift;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign shift_full    = {scratch_adj, op_reg} << 1;
    assign scratch_shift = shift_full[BCD_W+WIDTH-1:WIDTH];
    assign op_shift      = shift_full[WIDTH-1:0];

    // The last SHIFT cycle is the DONE-entry edge; results come straight
    // from the final shifted scratch value.
    logic last_shift;
    assign last_shift = (state_reg == SHIFT) && (cnt_reg == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_i)        state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0)  state_next = DONE;
            DONE:    if (ready_i)        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_reg)
            IDLE:    ready_o = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg       <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            bcd_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && valid_i) begin
                op_reg       <= operand;
                scratch_reg  <= '0;
                cnt_reg      <= CNT_LOAD;
                ovf_pend_reg <= sat;
            end else if (state_reg == SHIFT) begin
                op_reg      <= op_shift;
                scratch_reg <= scratch_shift;
                cnt_reg     <= cnt_reg - CNT_W'(1);
            end
            if (last_shift) begin
                bcd_reg <= scratch_shift;
                ovf_reg <= ovf_pend_reg;
            end
        end
    end

    assign bcd_o = bcd_reg;
    assign ovf_o = ovf_reg;

`ifdef BIN2BCD_BLANK_EN
    // Digit k (k>=1) blanks when it and every higher digit are zero; the
    // units digit never blanks so a zero value still shows "0".
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_reg;

    assign blank_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_next[gi] = (scratch_shift[BCD_W-1:gi*BCD_DIGIT_W] == '0);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blank_reg <= '0;
        end else if (last_shift) begin
            blank_reg <= blank_next;
        end
    end

    assign blank_o = blank_reg;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq (WIDTH=14, DIGITS=4). Expected values come from
// a decimal reference model using plain division/modulo on the saturated
// input value. Honours BIN2BCD_BLANK_EN when compiled with it.
module tb_bin2bcd_seq;

    logic        clk_i;
    logic        rst_ni;
    logic [13:0] bin_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] bcd_o;
    logic [3:0]  blank_o;
    logic        ovf_o;
    logic        valid_o;
    logic        ready_i;

    int pass_cnt  = 0;
    int check_cnt = 0;

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bin_i   (bin_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .bcd_o   (bcd_o),
        .blank_o (blank_o),
        .ovf_o   (ovf_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int unsigned ref_sat(input int unsigned x);
        return (x > 9999) ? 9999 : x;
    endfunction

    function automatic logic [15:0] ref_bcd(input int unsigned x);
        int unsigned m;
        logic [15:0] r;
        m = ref_sat(x);
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned x);
        return x > 9999;
    endfunction

    function automatic logic [3:0] ref_blank(input int unsigned x);
        logic [3:0] r;
        r = 4'b0000;
`ifdef BIN2BCD_BLANK_EN
        begin
            int unsigned m;
            int unsigned lim;
            m   = ref_sat(x);
            lim = 10;
            for (int k = 1; k < 4; k++) begin
                r[k] = (m < lim);
                lim  = lim * 10;
            end
        end
`endif
        return r;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Call at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic do_accept(input int unsigned x);
        bin_i   = 14'(x);
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        bin_i   = 14'($urandom);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        bin_i   = '0;
        repeat (3) @(negedge clk_i);
        check_cnt++;
        if ({bcd_o, blank_o, ovf_o, valid_o, ready_o} !== {16'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state: bcd=%h blank=%b ovf=%b valid=%b ready=%b, required 0000/0000/0/0/1",
                     bcd_o, blank_o, ovf_o, valid_o, ready_o);
        end else pass_cnt++;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        bit early;
        do_accept(1234);
        check_cnt++;
        if (ready_o !== 1'b0) begin
            $display("FAIL basic_busy: ready_o=%b during conversion, required 0", ready_o);
        end else pass_cnt++;
        // Accept edge counts as edge 1; valid_o must appear after edge 15.
        early = 1'b0;
        for (int i = 1; i < 14; i++) begin
            if (valid_o) early = 1'b1;
            @(negedge clk_i);
        end
        if (valid_o) early = 1'b1;
        check_cnt++;
        if (early) begin
            $display("FAIL basic_latency_early: valid_o=1 before 15 edges, required 0");
        end else pass_cnt++;
        @(negedge clk_i);
        check_cnt++;
        if (valid_o !== 1'b1) begin
            $display("FAIL basic_latency: valid_o=%b after 15 edges, required 1", valid_o);
        end else pass_cnt++;
        check_cnt++;
        if (bcd_o !== 16'h1234 || ovf_o !== 1'b0 || blank_o !== ref_blank(1234)) begin
            $display("FAIL basic_result: bcd=%h ovf=%b blank=%b, required 1234/0/%b",
                     bcd_o, ovf_o, blank_o, ref_blank(1234));
        end else pass_cnt++;
        release_result();
        check_cnt++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            $display("FAIL basic_handback: ready=%b valid=%b, required 1/0", ready_o, valid_o);
        end else pass_cnt++;
    endtask

    task automatic test_overflow();
        bit ok;
        do_accept(12345);
        wait_valid(ok);
        check_cnt++;
        if (!ok || bcd_o !== 16'h9999 || ovf_o !== 1'b1) begin
            $display("FAIL ovf_sat: got=%0b bcd=%h ovf=%b, required 9999/1", ok, bcd_o, ovf_o);
        end else pass_cnt++;
        release_result();
        do_accept(7);
        repeat (5) @(negedge clk_i);
        check_cnt++;
        if (bcd_o !== 16'h9999 || ovf_o !== 1'b1) begin
            $display("FAIL ovf_hold: bcd=%h ovf=%b mid-conversion, required 9999/1", bcd_o, ovf_o);
        end else pass_cnt++;
        wait_valid(ok);
        check_cnt++;
        if (!ok || bcd_o !== 16'h0007 || ovf_o !== 1'b0 || blank_o !== ref_blank(7)) begin
            $display("FAIL ovf_clear: got=%0b bcd=%h ovf=%b blank=%b, required 0007/0/%b",
                     ok, bcd_o, ovf_o, blank_o, ref_blank(7));
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_blank();
        bit ok;
        int unsigned vals[3] = '{42, 0, 305};
        foreach (vals[i]) begin
            do_accept(vals[i]);
            wait_valid(ok);
            check_cnt++;
            if (!ok || bcd_o !== ref_bcd(vals[i]) || blank_o !== ref_blank(vals[i])) begin
                $display("FAIL blank_%0d: got=%0b bcd=%h blank=%b, required %h/%b",
                         vals[i], ok, bcd_o, blank_o, ref_bcd(vals[i]), ref_blank(vals[i]));
            end else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit moved;
        logic [15:0] held;
        int unsigned x;
        x = $urandom_range(0, 9999);
        do_accept(x);
        // Stray offers during SHIFT must be ignored.
        for (int i = 0; i < 6; i++) begin
            bin_i   = 14'($urandom);
            valid_i = 1'b1;
            ready_i = 1'($urandom);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        wait_valid(ok);
        held  = bcd_o;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bin_i   = 14'($urandom);
            valid_i = 1'($urandom);
            @(negedge clk_i);
            if (valid_o !== 1'b1 || bcd_o !== held) moved = 1'b1;
        end
        valid_i = 1'b0;
        check_cnt++;
        if (!ok || moved) begin
            $display("FAIL bp_hold: got=%0b changed=%0b, required valid held and bcd stable", ok, moved);
        end else pass_cnt++;
        check_cnt++;
        if (bcd_o !== ref_bcd(x)) begin
            $display("FAIL bp_result: bcd=%h, required %h (input %0d)", bcd_o, ref_bcd(x), x);
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit ok;
        do_accept(5555);
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_cnt++;
        if ({bcd_o, blank_o, ovf_o, valid_o, ready_o} !== {16'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL rst_mid_state: bcd=%h blank=%b ovf=%b valid=%b ready=%b, required 0000/0000/0/0/1",
                     bcd_o, blank_o, ovf_o, valid_o, ready_o);
        end else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        check_cnt++;
        if (seen) begin
            $display("FAIL rst_mid_novalid: valid_o=1 after aborted conversion, required 0");
        end else pass_cnt++;
        do_accept(321);
        wait_valid(ok);
        check_cnt++;
        if (!ok || bcd_o !== 16'h0321 || ovf_o !== 1'b0) begin
            $display("FAIL rst_mid_next: got=%0b bcd=%h ovf=%b, required 0321/0", ok, bcd_o, ovf_o);
        end else pass_cnt++;
        release_result();
    endtask

    task automatic test_sweep();
        int unsigned vals[$];
        bit ok;
        vals = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
        for (int i = 0; i < 2500; i++) vals.push_back($urandom_range(0, 16383));
        foreach (vals[i]) begin
            repeat ($urandom_range(0, 2)) begin
                bin_i = 14'($urandom);
                @(negedge clk_i);
            end
            do_accept(vals[i]);
            wait_valid(ok);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            check_cnt++;
            if (!ok || bcd_o !== ref_bcd(vals[i]) || ovf_o !== ref_ovf(vals[i])
                || blank_o !== ref_blank(vals[i])) begin
                $display("FAIL sweep_%0d: got=%0b bcd=%h ovf=%b blank=%b, required %h/%b/%b",
                         vals[i], ok, bcd_o, ovf_o, blank_o,
                         ref_bcd(vals[i]), ref_ovf(vals[i]), ref_blank(vals[i]));
            end else pass_cnt++;
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_blank();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
